// File: rtl/mvu_pkg.sv
// Shared types and constants for the MVU bit-plane scheduler.
package mvu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  localparam int MODE_W = 1;
  localparam int MODE_D = 0;

  localparam int PMAX_DFLT = 16;

  // Control word layout is {clr, sh, mode[1:0]}; idle keeps the accumulator cleared.
  localparam logic [3:0] CTRL_IDLE = 4'b1000;

  function automatic int prec_w(input int pmax);
    return $clog2(pmax + 1);
  endfunction

  function automatic int clamp_prec(input int v, input int pmax);
    if (v < 1) return 1;
    if (v > pmax) return pmax;
    return v;
  endfunction

endpackage

// File: rtl/mvu_sched_if.sv
// Dispatcher and MVU/plane-buffer signals of the bit-plane scheduler.
interface mvu_sched_if #(
  parameter int PMAX = mvu_pkg::PMAX_DFLT,
  parameter int AW   = 10
);
  import mvu_pkg::*;
  localparam int PW = prec_w(PMAX);

  logic          start;
  logic [PW-1:0] wprec;
  logic [PW-1:0] dprec;
  logic          wsigned;
  logic          dsigned;
  logic [AW-1:0] wbase;
  logic [AW-1:0] dbase;
  logic          busy;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] d_addr;
  logic          rd_en;
  logic          clr;
  logic          sh;
  logic [1:0]    mode;
  logic          o_valid;

  modport master (
    output start, wprec, dprec, wsigned, dsigned, wbase, dbase,
    input  busy, w_addr, d_addr, rd_en, clr, sh, mode, o_valid
  );

  modport slave (
    input  start, wprec, dprec, wsigned, dsigned, wbase, dbase,
    output busy, w_addr, d_addr, rd_en, clr, sh, mode, o_valid
  );

endinterface

// File: rtl/mvu_sched_dly.sv
// Register delay line aligning {clr, sh, mode} with planes returning from the buffers.
module mvu_sched_dly
  import mvu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ck;
      assign unused_ck = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [3:0] stg [DEPTH];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) stg[k] <= CTRL_IDLE;
        end else begin
          stg[0] <= d;
          for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
        end
      end
      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mvu_sched.sv
// Bit-plane scheduler: walks (weight, data) plane pairs by descending significance.
// Signed plane handling is built only when MVU_SCHED_SIGNED_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for start, config sampled on accept
// ST_RUN   | one plane pair issued per cycle
// ST_DRAIN | waiting MEMLAT+ACCLAT cycles for the result
module mvu_sched
  import mvu_pkg::*;
#(
  parameter int PMAX   = PMAX_DFLT,
  parameter int AW     = 10,
  parameter int MEMLAT = 1,
  parameter int ACCLAT = 1
) (
  input logic      clk,
  input logic      rst_n,
  mvu_sched_if.slave bus
);

  localparam int PW = prec_w(PMAX);
  localparam int DL = MEMLAT + ACCLAT;
  localparam int CW = $clog2(DL + 1);

  sched_state_e  state, state_n;
  logic [PW-1:0] p_r, q_r, i_r, j_r;
  logic [PW-1:0] p_n, q_n, i_n, j_n;
  logic          first_r, first_n, news_r, news_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [AW-1:0] wbase_r, dbase_r, wbase_n, dbase_n;
  logic [1:0]    mode_now;
  logic [3:0]    ctrl_now, ctrl_dly;
  int            s_nx, i_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      p_r     <= '0;
      q_r     <= '0;
      i_r     <= '0;
      j_r     <= '0;
      first_r <= 1'b0;
      news_r  <= 1'b0;
      cnt_r   <= '0;
      wbase_r <= '0;
      dbase_r <= '0;
    end else begin
      state   <= state_n;
      p_r     <= p_n;
      q_r     <= q_n;
      i_r     <= i_n;
      j_r     <= j_n;
      first_r <= first_n;
      news_r  <= news_n;
      cnt_r   <= cnt_n;
      wbase_r <= wbase_n;
      dbase_r <= dbase_n;
    end
  end

  always_comb begin
    state_n = state;
    p_n     = p_r;
    q_n     = q_r;
    i_n     = i_r;
    j_n     = j_r;
    first_n = first_r;
    news_n  = news_r;
    cnt_n   = cnt_r;
    wbase_n = wbase_r;
    dbase_n = dbase_r;
    s_nx    = 0;
    i_nx    = 0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          p_n     = PW'(clamp_prec(int'(bus.wprec), PMAX));
          q_n     = PW'(clamp_prec(int'(bus.dprec), PMAX));
          i_n     = p_n - PW'(1);
          j_n     = q_n - PW'(1);
          first_n = 1'b1;
          news_n  = 1'b0;
          wbase_n = bus.wbase;
          dbase_n = bus.dbase;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        first_n = 1'b0;
        if (i_r == '0 && j_r == '0) begin
          news_n  = 1'b0;
          cnt_n   = CW'(DL);
          state_n = ST_DRAIN;
        end else if (i_r != '0 && j_r != q_r - PW'(1)) begin
          i_n    = i_r - PW'(1);
          j_n    = j_r + PW'(1);
          news_n = 1'b0;
        end else begin
          // Diagonal exhausted: drop one significance level, restart at the highest legal i.
          s_nx   = int'(i_r) + int'(j_r) - 1;
          i_nx   = (s_nx < int'(p_r) - 1) ? s_nx : int'(p_r) - 1;
          i_n    = PW'(i_nx);
          j_n    = PW'(s_nx - i_nx);
          news_n = 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_n = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef MVU_SCHED_SIGNED_EN
  logic ws_r, ds_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_r <= 1'b0;
      ds_r <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      ws_r <= bus.wsigned;
      ds_r <= bus.dsigned;
    end
  end

  always_comb begin
    mode_now         = 2'b00;
    mode_now[MODE_W] = ws_r && (i_r == p_r - PW'(1));
    mode_now[MODE_D] = ds_r && (j_r == q_r - PW'(1));
  end
`else
  logic unused_sgn;
  assign unused_sgn = bus.wsigned ^ bus.dsigned;
  assign mode_now   = 2'b00;
`endif

  assign bus.busy    = (state != ST_IDLE);
  assign bus.rd_en   = (state == ST_RUN);
  assign bus.w_addr  = wbase_r + AW'(i_r);
  assign bus.d_addr  = dbase_r + AW'(j_r);
  assign bus.o_valid = (state == ST_DRAIN) && (cnt_r == CW'(1));

  assign ctrl_now = bus.rd_en ? {first_r, news_r, mode_now} : CTRL_IDLE;

  mvu_sched_dly #(.DEPTH(MEMLAT)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_now),
    .q     (ctrl_dly)
  );

  assign {bus.clr, bus.sh, bus.mode} = ctrl_dly;

endmodule

// File: tb/tb_mvu_sched.sv
// Bench for mvu_sched: pair-order reference model checked every cycle plus fixed job cases.
module tb_mvu_sched;

  localparam int PMAX   = 16;
  localparam int AW     = 10;
  localparam int MEMLAT = 1;
  localparam int ACCLAT = 1;
  localparam int PW     = $clog2(PMAX + 1);
  localparam int L      = MEMLAT + ACCLAT;
  localparam int NP     = PMAX * PMAX + 1;
  localparam int OBS    = PMAX * PMAX + L + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mvu_sched_if #(.PMAX(PMAX), .AW(AW)) bus ();

  mvu_sched #(.PMAX(PMAX), .AW(AW), .MEMLAT(MEMLAT), .ACCLAT(ACCLAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int comps = 0;
  int fails = 0;
  int gcyc  = 0;

  bit act = 1'b0;
  int cyc = 0, pq = 0, mp = 0, mq = 0;
  logic [AW-1:0] m_wa [NP];
  logic [AW-1:0] m_da [NP];
  logic [3:0]    m_ctrl [NP];

  logic [AW-1:0] obs_wa [OBS];
  logic [AW-1:0] obs_da [OBS];
  logic [3:0]    obs_ctrl [OBS];
  logic          obs_rd [OBS];
  logic          obs_ov [OBS];
  int ov_count = 0;
  int rd_cnt   = 0;

  int ew22 [4] = '{1, 1, 0, 0};
  int ed22 [4] = '{1, 0, 1, 0};
  int es22 [4] = '{0, 1, 0, 1};
  int ec22 [4] = '{1, 0, 0, 0};
`ifdef MVU_SCHED_SIGNED_EN
  int em32 [6] = '{3, 2, 1, 0, 1, 0};
`else
  int em32 [6] = '{0, 0, 0, 0, 0, 0};
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    comps++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, gcyc, got, exp);
    end
  endtask

  function automatic int clampp(input int v);
    return (v < 1) ? 1 : ((v > PMAX) ? PMAX : v);
  endfunction

  // Enumerate pairs by significance diagonal, highest first.
  task automatic build(input int wp, input int dp, input logic [AW-1:0] wb,
                       input logic [AW-1:0] db, input bit ws, input bit dsg);
    int k = 0;
    int ihi, ilo;
    mp = clampp(wp);
    mq = clampp(dp);
    pq = mp * mq;
    for (int s = mp + mq - 2; s >= 0; s--) begin
      ihi = (s < mp - 1) ? s : mp - 1;
      ilo = (s - mq + 1 > 0) ? s - mq + 1 : 0;
      for (int i = ihi; i >= ilo; i--) begin
        k++;
        m_wa[k] = wb + AW'(i);
        m_da[k] = db + AW'(s - i);
        m_ctrl[k][3] = (k == 1);
        m_ctrl[k][2] = (k != 1) && (i == ihi);
`ifdef MVU_SCHED_SIGNED_EN
        m_ctrl[k][1] = ws && (i == mp - 1);
        m_ctrl[k][0] = dsg && (s - i == mq - 1);
`else
        m_ctrl[k][1:0] = {ws, dsg} & 2'b00;
`endif
      end
    end
  endtask

  task automatic compare();
    logic [3:0] ec;
    bit erd, eov;
    erd = act && (cyc <= pq);
    eov = act && (cyc == pq + L);
    ec  = (act && cyc - MEMLAT >= 1 && cyc - MEMLAT <= pq) ? m_ctrl[cyc-MEMLAT] : 4'b1000;
    chk("busy", bus.busy, act);
    chk("rd_en", bus.rd_en, erd);
    if (erd) begin
      chk("w_addr", bus.w_addr, m_wa[cyc]);
      chk("d_addr", bus.d_addr, m_da[cyc]);
    end
    chk("clr_sh_mode", {bus.clr, bus.sh, bus.mode}, ec);
    chk("o_valid", bus.o_valid, eov);
    if (act && cyc < OBS) begin
      obs_wa[cyc]   = bus.w_addr;
      obs_da[cyc]   = bus.d_addr;
      obs_ctrl[cyc] = {bus.clr, bus.sh, bus.mode};
      obs_rd[cyc]   = bus.rd_en;
      obs_ov[cyc]   = bus.o_valid;
    end
    if (bus.o_valid === 1'b1) ov_count++;
    if (bus.rd_en === 1'b1) rd_cnt++;
  endtask

  task automatic step();
    bit acc;
    @(posedge clk);
    gcyc++;
    acc = (rst_n === 1'b1) && !act && (bus.start === 1'b1);
    if (rst_n !== 1'b1) begin
      act = 1'b0;
      cyc = 0;
    end else if (act) begin
      if (cyc == pq + L) begin
        act = 1'b0;
        cyc = 0;
      end else begin
        cyc++;
      end
    end
    if (acc) begin
      build(int'(bus.wprec), int'(bus.dprec), bus.wbase, bus.dbase, bus.wsigned, bus.dsigned);
      act = 1'b1;
      cyc = 1;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic run_job(input int wp, input int dp, input int wb, input int db,
                         input bit ws, input bit dsg);
    bus.wprec   = PW'(wp);
    bus.dprec   = PW'(dp);
    bus.wbase   = AW'(wb);
    bus.dbase   = AW'(db);
    bus.wsigned = ws;
    bus.dsigned = dsg;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < NP + L + 4 && act; n++) step();
    chk("job_end_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ov_g, gap, rises, snap;
    bit prd, pbz;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.wprec   = '0;
    bus.dprec   = '0;
    bus.wsigned = 1'b0;
    bus.dsigned = 1'b0;
    bus.wbase   = '0;
    bus.dbase   = '0;

    repeat (3) step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_en", bus.rd_en, 1'b0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_d_addr", bus.d_addr, 0);
    chk("rst_clr", bus.clr, 1'b1);
    chk("rst_sh", bus.sh, 1'b0);
    chk("rst_mode", bus.mode, 2'b00);
    chk("rst_o_valid", bus.o_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();

    // 1x1 job at (5,9)
    run_job(1, 1, 5, 9, 1'b0, 1'b0);
    chk("p1_model_wa", m_wa[1], 5);
    chk("p1_rd", obs_rd[1], 1'b1);
    chk("p1_w_addr", obs_wa[1], 5);
    chk("p1_d_addr", obs_da[1], 9);
    chk("p1_clr_c2", obs_ctrl[2][3], 1'b1);
    chk("p1_ov_c2", obs_ov[2], 1'b0);
    chk("p1_ov_c3", obs_ov[3], 1'b1);

    // 2x2 unsigned
    run_job(2, 2, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("p2_model_i", m_wa[k+1], ew22[k]);
      chk("p2_i", obs_wa[k+1], ew22[k]);
      chk("p2_j", obs_da[k+1], ed22[k]);
      chk("p2_sh", obs_ctrl[k+2][2], es22[k]);
      chk("p2_clr", obs_ctrl[k+2][3], ec22[k]);
    end
    chk("p2_ov_c6", obs_ov[6], 1'b1);

    // 3x2 both signed
    run_job(3, 2, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("p3_model_mode", m_ctrl[k+1][1:0], em32[k]);
      chk("p3_mode", obs_ctrl[k+2][1:0], em32[k]);
    end

    // weight base at top of address space
    run_job(2, 1, (1 << AW) - 1, 0, 1'b0, 1'b0);
    chk("wrap_i1", obs_wa[1], 0);
    chk("wrap_i0", obs_wa[2], (1 << AW) - 1);

    // precision 0 -> 1, above PMAX -> PMAX
    rd_cnt = 0;
    run_job(0, 20, 3, 4, 1'b0, 1'b0);
    chk("clamp_model_pq", pq, 16);
    chk("clamp_rd_count", rd_cnt, 16);

    // start held high
    ov_g = -1; gap = -1; rises = 0; prd = 1'b0; pbz = 1'b0;
    bus.wprec = PW'(2);
    bus.dprec = PW'(1);
    bus.start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.o_valid === 1'b1 && ov_g < 0) ov_g = gcyc;
      if (bus.rd_en === 1'b1 && !prd && ov_g >= 0 && gap < 0) gap = gcyc - ov_g;
      if (bus.busy === 1'b1 && !pbz) rises++;
      prd = (bus.rd_en === 1'b1);
      pbz = (bus.busy === 1'b1);
    end
    bus.start = 1'b0;
    chk("b2b_gap", gap, 2);
    chk("b2b_jobs", rises, 4);
    for (int n = 0; n < 10 && act; n++) step();

    // reset in cycle 3 of a 4x4 job
    bus.wprec = PW'(4);
    bus.dprec = PW'(4);
    bus.wbase = AW'(7);
    bus.dbase = AW'(11);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_rd_en", bus.rd_en, 1'b0);
    chk("mrst_w_addr", bus.w_addr, 0);
    chk("mrst_d_addr", bus.d_addr, 0);
    chk("mrst_ctrl", {bus.clr, bus.sh, bus.mode}, 4'b1000);
    rst_n = 1'b1;
    snap = ov_count;
    repeat (30) step();
    chk("mrst_no_ov", ov_count - snap, 0);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.wprec   = PW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
      bus.dprec   = PW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
      bus.wbase   = AW'($urandom);
      bus.dbase   = AW'($urandom);
      bus.wsigned = $urandom_range(0, 1) == 1;
      bus.dsigned = $urandom_range(0, 1) == 1;
      rst_n       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    for (int n = 0; n < NP + L + 4 && act; n++) step();
    chk("final_idle", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
